// File: rtl/serial_word_framer.sv
// serial_word_framer: hunts for a sync pattern in a gated serial bit stream, then
// deserializes a fixed number of MSB-first words per frame into a show-ahead FIFO.
module serial_word_framer #(
    parameter int        WORD_W          = 8,
    parameter int        SYNC_W          = 8,
    parameter bit [31:0] SYNC_PAT        = 32'hA5,
    parameter int        WORDS_PER_FRAME = 4,
    parameter int        FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [WORD_W-1:0] word_out,
    output logic              word_sof,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              in_sync,
    output logic              overflow
);

    localparam int BCW = $clog2(WORD_W);
    localparam int HCW = $clog2(SYNC_W + 1);
    localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [SYNC_W-1:0] LP_PAT       = SYNC_PAT[SYNC_W-1:0];
    localparam logic [BCW-1:0]    LP_BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [HCW-1:0]    LP_HUNT_SAT  = HCW'(SYNC_W);
    localparam logic [HCW-1:0]    LP_HUNT_PRE  = HCW'(SYNC_W - 1);
    localparam logic [WCW-1:0]    LP_WORD_LAST = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [CW-1:0]     LP_FULL      = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t            r_state;
    logic [SYNC_W-1:0] r_sr;
    logic [HCW-1:0]    r_hunt_cnt;
    logic [WORD_W-1:0] r_acc;
    logic [BCW-1:0]    r_bit_cnt;
    logic [WCW-1:0]    r_word_cnt;
    logic              r_overflow;

    logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_sof_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [SYNC_W-1:0] w_sr_next;
    logic [WORD_W-1:0] w_word;
    logic              w_sync_hit;
    logic              w_word_done;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_sr_next   = {r_sr[SYNC_W-2:0], bit_in};
    assign w_word      = {r_acc[WORD_W-2:0], bit_in};
    // The bit count gate keeps the reset value of sr from matching an all-zero pattern early.
    assign w_sync_hit  = (w_sr_next == LP_PAT) && (r_hunt_cnt >= LP_HUNT_PRE);
    assign w_word_done = (r_state == ST_COLLECT) && bit_en && (r_bit_cnt == LP_BIT_LAST);
    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == LP_FULL);
    assign w_pop       = w_valid && word_ready;
    assign w_push      = w_word_done && (!w_full || w_pop);
    assign w_drop      = w_word_done && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_hunt_cnt <= '0;
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            case (r_state)
                ST_HUNT: begin
                    if (bit_en) begin
                        r_sr <= w_sr_next;
                        if (r_hunt_cnt != LP_HUNT_SAT) begin
                            r_hunt_cnt <= r_hunt_cnt + 1'b1;
                        end
                        if (w_sync_hit) begin
                            r_state    <= ST_COLLECT;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (bit_en) begin
                        r_acc <= w_word;
                        if (r_bit_cnt == LP_BIT_LAST) begin
                            r_bit_cnt  <= '0;
                            r_word_cnt <= r_word_cnt + 1'b1;
                            // Frame end or a dropped word both force a full re-hunt.
                            if (w_drop || (r_word_cnt == LP_WORD_LAST)) begin
                                r_state    <= ST_HUNT;
                                r_sr       <= '0;
                                r_hunt_cnt <= '0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr]     <= w_word;
            r_sof_mem[r_wr_ptr] <= (r_word_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign word_valid = w_valid;
    assign word_out   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign word_sof   = w_valid && r_sof_mem[r_rd_ptr];
    assign in_sync    = (r_state == ST_COLLECT);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_word_framer.sv
// Scoreboard bench for serial_word_framer: stimulus queues expected words, a
// negedge monitor pops and compares whenever a word is handed off.
module tb_serial_word_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b0;
    logic bit_en = 1'b0;
    logic word_ready = 1'b0;

    logic [7:0] word_out;
    logic       word_sof, word_valid, in_sync, overflow;
    logic [3:0] z_word_out;
    logic       z_word_sof, z_word_valid, z_in_sync, z_overflow;

    int n_checks = 0;
    int n_fail = 0;
    int sync_bits = 0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    serial_word_framer #(
        .WORD_W(8), .SYNC_W(8), .SYNC_PAT(32'hA5), .WORDS_PER_FRAME(4), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
        .word_out(word_out), .word_sof(word_sof), .word_valid(word_valid),
        .word_ready(word_ready), .in_sync(in_sync), .overflow(overflow)
    );

    serial_word_framer #(
        .WORD_W(4), .SYNC_W(8), .SYNC_PAT(32'h0), .WORDS_PER_FRAME(4), .FIFO_DEPTH(4)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
        .word_out(z_word_out), .word_sof(z_word_sof), .word_valid(z_word_valid),
        .word_ready(word_ready), .in_sync(z_in_sync), .overflow(z_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_word", {23'd0, word_sof, word_out}, 32'h1_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("mon_word_out", word_out, e[7:0]);
                check("mon_word_sof", word_sof, e[8]);
            end
        end
    end

    task automatic send_bit(input logic b);
        if (in_sync) sync_bits++;
        bit_in = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gap(input int n, input logic exp_sync);
        bit_en = 1'b0;
        repeat (n) begin
            bit_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("gap_in_sync", in_sync, exp_sync);
    endtask

    task automatic do_reset();
        word_ready = 1'b0;
        bit_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_word_out"}, word_out, 0);
        check({tag, "_word_sof"}, word_sof, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_in_sync"}, in_sync, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic send_sync_checked(input string tag);
        logic [7:0] p;
        p = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            send_bit(p[i]);
            check({tag, "_early_sync"}, in_sync, 0);
        end
        send_bit(p[0]);
        check({tag, "_locked"}, in_sync, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        word_ready = 1'b1;
        while (word_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drain_valid"}, word_valid, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] words [4];
        logic [7:0] p;

        // Reset state
        do_reset();
        check_outputs_zero("reset");
        check("reset_z_valid", z_word_valid, 0);
        check("reset_z_in_sync", z_in_sync, 0);

        // Basic frame
        word_ready = 1'b1;
        send_sync_checked("basic");
        words = '{8'h3C, 8'h81, 8'hFF, 8'h00};
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 0), words[w]});
        sync_bits = 0;
        for (int w = 0; w < 4; w++) begin
            send_byte(words[w]);
            check("basic_valid_latency", word_valid, 1);
            check("basic_head", word_out, words[w]);
        end
        check("basic_sync_bits", sync_bits, 32);
        check("basic_back_to_hunt", in_sync, 0);
        send_bit(1'b0);
        check("basic_valid_drops", word_valid, 0);
        check("basic_queue_empty", exp_q.size(), 0);

        // Lookalike and gaps
        do_reset();
        word_ready = 1'b1;
        p = 8'hA4;
        for (int i = 7; i >= 0; i--) begin
            send_bit(p[i]);
            check("look_no_sync", in_sync, 0);
            gap($urandom_range(0, 2), 1'b0);
        end
        p = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            send_bit(p[i]);
            check("look_no_sync2", in_sync, 0);
            gap($urandom_range(0, 2), 1'b0);
        end
        send_bit(p[0]);
        check("look_locked", in_sync, 1);
        gap(3, 1'b1);
        words = '{8'hA5, 8'hA5, 8'h5A, 8'hA5};
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 0), words[w]});
        sync_bits = 0;
        for (int w = 0; w < 4; w++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(words[w][i]);
                if (i == 4) gap($urandom_range(1, 3), (w != 3) || (i != 0));
            end
        end
        check("look_sync_bits", sync_bits, 32);
        check("look_back_to_hunt", in_sync, 0);
        send_sync_checked("look_resync");
        do_reset();

        // Overflow
        word_ready = 1'b0;
        send_sync_checked("ovf_f1");
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 0), words[w]});
        for (int w = 0; w < 4; w++) send_byte(words[w]);
        check("ovf_full_valid", word_valid, 1);
        check("ovf_head", word_out, 8'h11);
        check("ovf_head_sof", word_sof, 1);
        check("ovf_f1_hunt", in_sync, 0);
        send_sync_checked("ovf_f2");
        send_byte(8'h55);
        check("ovf_pulse", overflow, 1);
        check("ovf_in_sync_fall", in_sync, 0);
        send_bit(1'b0);
        check("ovf_pulse_end", overflow, 0);
        send_byte(8'h66);
        check("ovf_stay_hunt", in_sync, 0);
        check("ovf_no_second_pulse", overflow, 0);
        check("ovf_head_kept", word_out, 8'h11);
        drain("ovf");

        // Full with simultaneous pop
        do_reset();
        send_sync_checked("fp_f1");
        words = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 0), words[w]});
        for (int w = 0; w < 4; w++) send_byte(words[w]);
        send_sync_checked("fp_f2");
        words = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 0), words[w]});
        for (int i = 7; i >= 1; i--) send_bit(words[0][i]);
        word_ready = 1'b1;
        send_bit(words[0][0]);
        check("fp_no_overflow", overflow, 0);
        check("fp_still_sync", in_sync, 1);
        check("fp_valid", word_valid, 1);
        check("fp_next_head", word_out, 8'hC2);
        for (int w = 1; w < 4; w++) begin
            send_byte(words[w]);
            check("fp_no_overflow_tail", overflow, 0);
        end
        drain("fp");

        // Reset mid-frame
        do_reset();
        send_sync_checked("rm");
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("rm_one_queued", word_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        check_outputs_zero("rm");
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(8'h66);
        send_byte(8'h77);
        check("rm_ignored_sync", in_sync, 0);
        check("rm_ignored_valid", word_valid, 0);
        send_sync_checked("rm_resync");
        do_reset();

        // Sync with pattern 0 (second instance)
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0);
            check("p0_early_sync", z_in_sync, 0);
        end
        send_bit(1'b0);
        check("p0_locked", z_in_sync, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("p0_word_valid", z_word_valid, 1);
        check("p0_word_out", z_word_out, 4'h9);
        check("p0_word_sof", z_word_sof, 1);
        check("p0_main_unlocked", in_sync, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_framer.md
# serial_word_framer

Downstream consumer of the single-bit registered stream produced by the D flip-flop stage. It hunts for a sync pattern in the serial bit stream, then deserializes a fixed number of words per frame, MSB first. Words go into a small show-ahead FIFO and leave through a valid/ready interface toward the parallel datapath. Overflow is reported, and the frame is abandoned on overflow.

## Interface
- WORD_W, 8, bits per deserialized word (2..32)
- SYNC_W, 8, sync pattern length in bits (2..32)
- SYNC_PAT, 8'hA5, sync pattern, MSB received first
- WORDS_PER_FRAME, 4, words collected after each sync (1..256)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
- bit_in  input  1  serial data bit (flip-flop q output)
- bit_en  input  1  bit_in is sampled only on edges where bit_en=1
- word_out  output  WORD_W  FIFO head word
- word_sof  output  1  head word is first word of its frame
- word_valid  output  1  FIFO non-empty
- word_ready  input  1  consumer accepts head when word_valid & word_ready
- in_sync  output  1  FSM in COLLECT
- overflow  output  1  one-cycle pulse: word dropped, frame aborted

## Operation
- FSM states: HUNT, COLLECT.
- Reset (rst_n=0 at an edge) has these effects:
  - state=HUNT; shift register, hunt_cnt, bit_cnt and word_cnt cleared.
  - FIFO emptied.
  - word_out=0, word_sof=0, word_valid=0, in_sync=0, overflow=0.
  - Reset overrides all other inputs on the same edge.
- HUNT behaviour:
  - Each accepted bit shifts in: sr <= {sr[SYNC_W-2:0], bit_in}.
  - hunt_cnt saturates at SYNC_W.
  - Transition to COLLECT happens when the post-shift sr == SYNC_PAT and at least SYNC_W bits have been accepted since entering HUNT. This rule also applies to SYNC_PAT=0.
  - On that transition, bit_cnt=0 and word_cnt=0.
- COLLECT behaviour:
  - Each accepted bit shifts into the word accumulator, MSB first.
  - On the WORD_W-th bit, the completed word is pushed with sof=(word_cnt==0).
  - bit_cnt wraps to 0 and word_cnt increments.
  - After push number WORD_PER_FRAME (word_cnt reaches WORDS_PER_FRAME-1 at push), go to HUNT and clear sr and hunt_cnt. Sync must be fully re-received; bits already in the frame never count toward sync.
- Push succeeds if the FIFO is not full, or if a pop occurs on the same edge (full with simultaneous pop → push accepted, count unchanged).
- Push blocked by a full FIFO:
  - The word is discarded.
  - overflow=1 for exactly one cycle.
  - The FSM returns to HUNT with sr and hunt_cnt cleared.
  - Words already in the FIFO are kept.
- Pop happens on any edge with word_valid & word_ready. Asserting word_ready while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH. A count of FIFO_DEPTH+1 values distinguishes full from empty.
- The consumer must hold word_ready independent of word_valid to avoid combinational loops; word_valid never depends on word_ready.

## Timing
- in_sync rises on the edge that samples the last sync bit, and is visible the following cycle.
- Word latency: word_out/word_sof/word_valid update on the edge that samples the last bit of a word, if the FIFO was empty. That is 1 cycle, with no added pipeline.
- The FIFO is show-ahead. word_out and word_sof are stable while word_valid=1 and no pop occurs.
- After a pop, the next entry is presented the following cycle. word_valid drops the cycle after the last pop.
- in_sync falls the cycle after the final word push or the overflow edge.
- bit_en=0 stalls all counters and shift registers. The FIFO still pops.

## Test plan
- Basic frame test:
  - Stimulus: word_ready=1; bits 10100101 (A5), then 3C, 81, FF, 00.
  - Required response: four words, in order 3C(sof=1), 81, FF, 00, each with word_valid 1 cycle after its last bit; in_sync high for exactly 32 accepted bits; back to HUNT.
- Lookalike and gaps:
  - Stimulus: stream 1010010 1 0100101 with random bit_en=0 gaps; first bits after reset 0xA5 preceded by only 7 bits.
  - Required response: lock only after the full 8-bit match; in_sync is unaffected by the gaps; a frame tail containing A5 does not re-sync mid-frame.
- Overflow:
  - Stimulus: word_ready=0; two back-to-back frames (FIFO_DEPTH=4).
  - Required response: frame 1 fills the FIFO; the first word of frame 2 is dropped, overflow pulses once, in_sync falls, FSM is in HUNT; when word_ready=1, 4 words of frame 1 drain in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full; word_ready=1 on the exact edge a new word completes.
  - Required response: no overflow; FIFO stays full; ordering is preserved.
- Reset mid-frame:
  - Stimulus: rst_n=0 for one edge after sync plus 12 bits, with 1 word queued.
  - Required response: all outputs 0 the next cycle; FIFO empty; the remaining bits are ignored until a new A5 is received.
- Sync with pattern 0:
  - Stimulus: SYNC_PAT=0, WORD_W=4; reset then 8 zero bits.
  - Required response: lock on the 8th bit, not earlier.
